// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - frame constants and state encoding shared by SPI initiator and responder
`timescale 1ns/1ps
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 8;
  localparam logic RW_READ  = 1'b1;

  // Rising-edge number that completes the R/W + address header
  localparam int HEADER_BITS = FRAME_BITS - DATA_BITS;

  typedef enum logic [2:0] {
    s_IDLE,
    s_ADDRESS,
    s_WRDATA,
    s_RDWAIT,
    s_RDDATA,
    s_DONE
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser with rise/fall detect on the last two samples
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VALUE}};
      prev  <= RESET_VALUE;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - oversampled SPI responder decoding 16-bit frames into register strobes
`timescale 1ns/1ps
module spi_responder
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY  = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_sen,
  input  logic                 i_sck,
  input  logic                 i_sdi,
  output logic                 o_sdo,
  output logic                 o_sdoEnable,
  output logic                 o_wrStrobe,
  output logic [ADDR_BITS-1:0] o_wrAddress,
  output logic [DATA_BITS-1:0] o_wrData,
  output logic                 o_rdStrobe,
  output logic [ADDR_BITS-1:0] o_rdAddress,
  input  logic [DATA_BITS-1:0] i_rdData,
  output logic                 o_busy,
  output logic                 o_frameError
);

  localparam int WAIT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY);
  localparam logic [3:0] HDR_LAST_EDGE   = 4'(HEADER_BITS - 1);
  localparam logic [3:0] FRAME_LAST_EDGE = 4'(FRAME_BITS - 1);
  localparam logic [3:0] FIRST_SHIFT     = 4'(HEADER_BITS + 1);

  logic sen_q, sen_rise, sen_fall;
  logic sck_q, sck_rise, sck_fall;
  logic sdi_q, sdi_rise, sdi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sen (
    .clk(i_clock), .rst(i_reset), .d(i_sen), .q(sen_q), .rise(sen_rise), .fall(sen_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sck (
    .clk(i_clock), .rst(i_reset), .d(i_sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sdi (
    .clk(i_clock), .rst(i_reset), .d(i_sdi), .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sen_q, sck_q, sdi_rise, sdi_fall};

  spi_state_t           state;
  logic [3:0]           bit_count;
  logic [DATA_BITS-1:0] rx_shift;
  logic [DATA_BITS-1:0] rx_next;
  logic [DATA_BITS-1:0] tx_shift;
  logic [ADDR_BITS-1:0] addr_latch;
  logic [WAIT_W-1:0]    wait_count;
  logic                 overrun;

  // sdi shares the sck pipeline depth, so sdi_q is the bit under the detected rising edge
  assign rx_next = {rx_shift[DATA_BITS-2:0], sdi_q};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= s_IDLE;
      bit_count    <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      addr_latch   <= '0;
      wait_count   <= '0;
      overrun      <= 1'b0;
      o_sdo        <= 1'b0;
      o_sdoEnable  <= 1'b0;
      o_wrStrobe   <= 1'b0;
      o_wrAddress  <= '0;
      o_wrData     <= '0;
      o_rdStrobe   <= 1'b0;
      o_rdAddress  <= '0;
      o_busy       <= 1'b0;
      o_frameError <= 1'b0;
    end else begin
      o_wrStrobe   <= 1'b0;
      o_rdStrobe   <= 1'b0;
      o_frameError <= 1'b0;

      // SEN release wins over any SCK edge seen in the same cycle
      if (sen_rise) begin
        if (state == s_DONE) begin
          o_frameError <= overrun;
        end else if (state != s_IDLE) begin
          o_frameError <= 1'b1;
        end
        state       <= s_IDLE;
        bit_count   <= '0;
        overrun     <= 1'b0;
        o_busy      <= 1'b0;
        o_sdo       <= 1'b0;
        o_sdoEnable <= 1'b0;
      end else begin
        case (state)
          s_IDLE: begin
            if (sen_fall) begin
              state     <= s_ADDRESS;
              bit_count <= '0;
              rx_shift  <= '0;
              overrun   <= 1'b0;
              o_busy    <= 1'b1;
            end
          end

          s_ADDRESS: begin
            if (sck_rise) begin
              rx_shift  <= rx_next;
              bit_count <= bit_count + 4'd1;
              if (bit_count == HDR_LAST_EDGE) begin
                addr_latch <= rx_next[ADDR_BITS-1:0];
                if (rx_next[DATA_BITS-1] == RW_READ) begin
                  o_rdStrobe  <= 1'b1;
                  o_rdAddress <= rx_next[ADDR_BITS-1:0];
                  wait_count  <= '0;
                  state       <= s_RDWAIT;
                end else begin
                  state <= s_WRDATA;
                end
              end
            end
          end

          s_WRDATA: begin
            if (sck_rise) begin
              rx_shift <= rx_next;
              if (bit_count == FRAME_LAST_EDGE) begin
                o_wrStrobe  <= 1'b1;
                o_wrAddress <= addr_latch;
                o_wrData    <= rx_next;
                state       <= s_DONE;
              end else begin
                bit_count <= bit_count + 4'd1;
              end
            end
          end

          s_RDWAIT: begin
            if (sck_rise && bit_count != FRAME_LAST_EDGE) begin
              bit_count <= bit_count + 4'd1;
            end
            if (wait_count == WAIT_LAST) begin
              tx_shift    <= i_rdData;
              o_sdo       <= i_rdData[DATA_BITS-1];
              o_sdoEnable <= 1'b1;
              state       <= s_RDDATA;
            end else begin
              wait_count <= wait_count + 1'b1;
            end
          end

          s_RDDATA: begin
            if (sck_rise) begin
              if (bit_count == FRAME_LAST_EDGE) begin
                o_sdo       <= 1'b0;
                o_sdoEnable <= 1'b0;
                state       <= s_DONE;
              end else begin
                bit_count <= bit_count + 4'd1;
              end
            end else if (sck_fall && bit_count >= FIRST_SHIFT) begin
              // The fall after edge 8 keeps data[7]; later falls advance one bit each
              tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};
              o_sdo    <= tx_shift[DATA_BITS-2];
            end
          end

          s_DONE: begin
            if (sck_rise) begin
              overrun <= 1'b1;
            end
          end

          default: begin
            state <= s_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI responder (slave) for the 16-bit register-access protocol our SPI initiator drives.
- Frame is MSB first: bit15 R/W (1=read, 0=write), bits14:8 address, bits7:0 data. SEN is active low, SCK idles low, and both sides sample on the SCK rising edge.
- Oversamples SEN/SCK/SDI in the i_clock domain, decodes frames and drives a simple register-bank strobe interface.
- Used as the FPGA-side peripheral port and as the bench partner for the initiator.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on i_sen/i_sck/i_sdi (min 2).
- RD_LATENCY, 2, i_clock cycles from o_rdStrobe to valid i_rdData (min 1).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_sen  in  1  chip enable from initiator, active low.
- i_sck  in  1  serial clock from initiator.
- i_sdi  in  1  serial data from initiator.
- o_sdo  out  1  serial read data to initiator.
- o_sdoEnable  out  1  high while o_sdo is driven (read data phase).
- o_wrStrobe  out  1  one-cycle write pulse.
- o_wrAddress  out  7  write address, valid with o_wrStrobe.
- o_wrData  out  8  write data, valid with o_wrStrobe.
- o_rdStrobe  out  1  one-cycle read request.
- o_rdAddress  out  7  read address, held from o_rdStrobe until frame end.
- i_rdData  in  8  read data, sampled RD_LATENCY cycles after o_rdStrobe.
- o_busy  out  1  high when state != s_IDLE.
- o_frameError  out  1  one-cycle pulse on a short or over-long frame.

Behaviour:
- Reset (async, i_reset=1):
  - All outputs are 0; state is s_IDLE; bit counter and shift registers are 0.
  - SEN and SCK synchroniser flops reset to 0. A frame already in progress at reset release therefore produces no SEN falling edge and is ignored until SEN goes high.
- Edge detection uses the last two synchronised samples. Frame start is a SEN falling edge; frame end is a SEN rising edge; bits are counted on SCK rising edges.
- Timing requirements on the initiator:
  - SCK half-period >= SYNC_STAGES+RD_LATENCY+3 i_clock cycles.
  - SEN high time >= SYNC_STAGES+1 cycles.
- States and transitions:
  - s_IDLE: on SEN falling edge -> s_ADDRESS with bitCount=0. SCK edges while in s_IDLE are ignored.
  - s_ADDRESS: shift i_sdi in on each rising edge. On the 8th rising edge, latch R/W and the address.
    - Write -> s_WRDATA.
    - Read -> s_RDWAIT, and pulse o_rdStrobe in that same cycle with o_rdAddress.
  - s_WRDATA: shift 8 more bits. On the 16th rising edge, pulse o_wrStrobe for 1 cycle with o_wrAddress/o_wrData, then -> s_DONE.
  - s_RDWAIT: wait RD_LATENCY cycles, load i_rdData into the tx shifter, then -> s_RDDATA.
    - o_sdo = data[7] and o_sdoEnable=1 from the load cycle on, i.e. before SCK falls after edge 8.
  - s_RDDATA: on each SCK falling edge that follows rising edges 9..15, shift so o_sdo presents data[6]..data[0]. On the 16th rising edge -> s_DONE.
  - s_DONE: o_sdoEnable=0. Extra rising edges set an internal overrun flag; a committed write is not undone. On SEN rising edge -> s_IDLE, and pulse o_frameError if overrun was set.
- Abort: SEN rising edge in s_ADDRESS/s_WRDATA/s_RDWAIT/s_RDDATA:
  - -> s_IDLE and pulse o_frameError.
  - No o_wrStrobe is issued.
  - An o_rdStrobe already issued stands; read side effects are the register bank's concern.
- SEN rising edge and an SCK rising edge in the same cycle: SEN wins (abort). That SCK edge is not counted.
- o_sdo is 0 whenever o_sdoEnable=0.
- o_rdAddress holds until the next o_rdStrobe. o_wrAddress/o_wrData hold until the next o_wrStrobe.
- Bit counter is 4 bits, 0..15, and never wraps inside a frame; s_DONE absorbs any further edges.

Decomposition:
- Shared package spi_pkg holds:
  - frame constants: FRAME_BITS=16, ADDR_BITS=7, DATA_BITS=8, RW_READ=1'b1;
  - the state encoding shared by initiator and responder benches.
- One sub-module, spi_sync_edge (SYNC_STAGES synchroniser plus rise/fall detect, reset value as a parameter), instantiated three times.

Test Plan:
- Write frame, addr 0x2A, data 0x5C, CLOCKS_PER_BIT=30 -> exactly one o_wrStrobe with o_wrAddress=0x2A and o_wrData=0x5C; o_frameError=0; o_sdoEnable stays 0.
- Read frame, addr 0x11, bank returns 0xA5 at RD_LATENCY=2 -> o_rdStrobe once with o_rdAddress=0x11; o_sdo sampled at rising edges 9..16 = 1,0,1,0,0,1,0,1; o_busy falls after SEN rises.
- Abort: SEN raised after 10 SCK rising edges of a write -> o_frameError pulses once, no o_wrStrobe, state returns to s_IDLE; a following write frame to 0x01 with data 0xFF succeeds.
- Reset asserted mid-frame with SEN held low, then released -> remaining SCK edges produce no strobes; after SEN high then low again, a new frame decodes correctly.
- Overrun: write frame with 17 SCK rising edges -> o_wrStrobe once at edge 16 with correct data, and o_frameError pulses at the SEN rising edge.
- Back-to-back write then read with SEN high for SYNC_STAGES+1 cycles between frames -> both frames decode correctly and no o_frameError is asserted.
